mlp_train_scheduler: RTL
========================

MLP_TRAIN_SCHEDULER -- requirements
Module: mlp_train_scheduler

Interface
REQ-001 SHALL have parameter INPUTS, default 2: number of MLP input values.
REQ-002 SHALL have parameter OUTPUTS, default 1: number of MLP outputs.
REQ-003 SHALL have parameter NUM_SAMPLES, default 4: depth of the sample table.
REQ-004 SHALL have parameter EPOCHS, default 100: epochs per run.
REQ-005 SHALL have parameter HOLD_CYCLES, default 2 (minimum 1): cycles each sample is held on the MLP inputs.
REQ-006 SHALL have parameter THRESHOLD (real), default 0.5: classification threshold.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-009 SHALL have ports wr_en, wr_addr ($clog2(NUM_SAMPLES) bits), wr_values (real[INPUTS]) and wr_expected (real[OUTPUTS]), all inputs: sample-table write port.
REQ-010 SHALL have ports start and abort, inputs, 1 bit each: begin a run and cancel a run.
REQ-011 SHALL have port prediction, input, real[OUTPUTS]: MLP output.
REQ-012 SHALL have ports values (real[INPUTS]), expected (real[OUTPUTS]) and training (1 bit), all outputs: drive the MLP.
REQ-013 SHALL have status outputs busy (1), done (1), epoch_done (1), epoch ($clog2(EPOCHS+1)), sample_idx ($clog2(NUM_SAMPLES)) and correct_count ($clog2(NUM_SAMPLES+1)).

Function
REQ-014 SHALL implement a state machine with states IDLE, TRAIN, EVAL and DONE.
REQ-015 SHALL write the table entry at wr_addr on a clock with wr_en=1 only when busy=0; the write is ignored when busy=1.
REQ-016 SHALL, on start=1 in IDLE or DONE, go to TRAIN at the next edge with epoch=0, sample_idx=0, busy=1 and done=0; start is ignored while busy=1.
REQ-017 SHALL, in TRAIN, drive values/expected from the registered table entry sample_idx, drive training=1, and hold each sample exactly HOLD_CYCLES cycles before advancing sample_idx.
REQ-018 SHALL, after the last TRAIN sample, enter EVAL with sample_idx=0 and training=0, holding each sample HOLD_CYCLES cycles.
REQ-019 SHALL, in EVAL on the final hold cycle of a sample, score a hit when, for every output k, (prediction[k] < THRESHOLD) equals (expected[k] < THRESHOLD).
REQ-020 SHALL accumulate hits in an internal pass counter and, at the edge ending the last EVAL sample, load correct_count with the pass total including that sample's hit.
REQ-021 SHALL, at that same edge, increment epoch and pulse epoch_done high for exactly one cycle.
REQ-022 SHALL enter TRAIN for the next epoch when the incremented epoch is below EPOCHS, and otherwise enter DONE.
REQ-023 SHALL make each epoch exactly 2*NUM_SAMPLES*HOLD_CYCLES cycles, with no idle cycles between samples, phases or epochs.
REQ-024 SHALL, in DONE, hold done=1, busy=0 and training=0, keep epoch and correct_count, and hold done until the next start.
REQ-025 SHALL, on abort=1 while busy, go to IDLE at the next edge with busy=0, training=0 and done=0; abort has priority over start, and epoch and correct_count are retained.
REQ-026 SHALL keep sample_idx and the hold counter free of wrap-around faults, so that sample_idx never exceeds NUM_SAMPLES-1.

Reset
REQ-027 SHALL, on rst=0 at a clock edge, enter IDLE and clear busy, done, epoch_done, training, epoch, sample_idx, correct_count, the pass counter and values/expected (to 0.0), regardless of state.
REQ-028 SHALL preserve sample-table contents across reset.

Configuration
REQ-029 SHALL, with macro MLP_SCHED_EARLY_STOP_EN defined, enter DONE after any epoch whose correct_count equals NUM_SAMPLES, even when epoch < EPOCHS.
REQ-030 SHALL, without MLP_SCHED_EARLY_STOP_EN, always run all EPOCHS epochs.

Verification
REQ-031 SHALL check: reset with rst=0 mid-TRAIN -> next cycle is IDLE, all outputs 0, and table contents unchanged.
REQ-032 SHALL check: XOR table loaded, NUM_SAMPLES=4, HOLD_CYCLES=2, EPOCHS=3, start -> busy high for 48 cycles, epoch_done pulses at cycles 16, 32 and 48, then done=1 and epoch=3.
REQ-033 SHALL check: prediction forced to 0.9 for all samples in EVAL -> correct_count=2 after each epoch.
REQ-034 SHALL check: abort at cycle 20 of a run -> IDLE next cycle, done=0, and epoch=1 retained; start again -> epoch restarts at 0.
REQ-035 SHALL check: wr_en pulsed while busy=1 -> table unchanged; start pulsed while busy=1 -> no restart.
REQ-036 SHALL check: with MLP_SCHED_EARLY_STOP_EN defined and a perfect prediction, EPOCHS=100 -> done after epoch 1 with correct_count=4.

Source files
------------

// File: rtl/mlp_train_scheduler.sv
// mlp_train_scheduler: sequences a small sample table into an MLP for training.
// Each epoch is a TRAIN pass followed by an EVAL pass over the whole table.
// Every sample is held on the MLP inputs for HOLD_CYCLES cycles. During EVAL the
// scheduler scores thresholded predictions against the expected values.
// Optional feature: define MLP_SCHED_EARLY_STOP_EN to stop a run after the first
// epoch in which every sample is classified correctly.
module mlp_train_scheduler #(
   parameter int  INPUTS      = 2,
   parameter int  OUTPUTS     = 1,
   parameter int  NUM_SAMPLES = 4,
   parameter int  EPOCHS      = 100,
   parameter int  HOLD_CYCLES = 2,
   parameter real THRESHOLD   = 0.5,
   localparam int IW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
   localparam int EW = $clog2(EPOCHS + 1),
   localparam int CW = $clog2(NUM_SAMPLES + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_addr,
   input  real           wr_values [INPUTS],
   input  real           wr_expected [OUTPUTS],
   input  logic          start,
   input  logic          abort,
   input  real           prediction [OUTPUTS],
   output real           values [INPUTS],
   output real           expected [OUTPUTS],
   output logic          training,
   output logic          busy,
   output logic          done,
   output logic          epoch_done,
   output logic [EW-1:0] epoch,
   output logic [IW-1:0] sample_idx,
   output logic [CW-1:0] correct_count
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_SAMPLES - 1);
   localparam logic [EW-1:0] EPOCHS_V  = EW'(EPOCHS);
   localparam logic [CW-1:0] ALL_HITS  = CW'(NUM_SAMPLES);

   typedef enum logic [1:0] {IDLE, TRAIN, EVAL, DONE} state_t;

   // Sample table; no reset so contents survive a scheduler reset.
   real tbl_values_q   [NUM_SAMPLES][INPUTS];
   real tbl_expected_q [NUM_SAMPLES][OUTPUTS];

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [EW-1:0] epoch_q, epoch_d;
   logic [CW-1:0] pass_q, pass_d;
   logic [CW-1:0] cc_q, cc_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          training_q, training_d;
   logic          epoch_done_q, epoch_done_d;
   real           values_q   [INPUTS];
   real           values_d   [INPUTS];
   real           expected_q [OUTPUTS];
   real           expected_d [OUTPUTS];

   logic [OUTPUTS-1:0] out_match;
   logic               sample_hit;
   logic               last_hold;
   logic               last_idx;
   logic               stop_now;
   logic [EW-1:0]      epoch_inc;
   logic [CW-1:0]      pass_total;

   genvar gi;

   // A sample scores a hit only when every output lands on the same side of the threshold.
   generate
      for (gi = 0; gi < OUTPUTS; gi++) begin : g_match
         assign out_match[gi] = ((prediction[gi] < THRESHOLD) == (expected_q[gi] < THRESHOLD));
      end
      for (gi = 0; gi < INPUTS; gi++) begin : g_values
         assign values[gi] = values_q[gi];
      end
      for (gi = 0; gi < OUTPUTS; gi++) begin : g_expected
         assign expected[gi] = expected_q[gi];
      end
   endgenerate

   assign sample_hit    = &out_match;
   assign training      = training_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign epoch_done    = epoch_done_q;
   assign epoch         = epoch_q;
   assign sample_idx    = idx_q;
   assign correct_count = cc_q;

   // Table write port; writes are locked out while a run is in progress.
   always_ff @(posedge clk) begin
      if (wr_en && !busy_q && (int'(wr_addr) < NUM_SAMPLES)) begin
         for (int i = 0; i < INPUTS; i++) begin
            tbl_values_q[wr_addr][i] <= wr_values[i];
         end
         for (int k = 0; k < OUTPUTS; k++) begin
            tbl_expected_q[wr_addr][k] <= wr_expected[k];
         end
      end
   end

   // Next-state logic: sample/hold sequencing, scoring and epoch bookkeeping.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      hold_d       = hold_q;
      epoch_d      = epoch_q;
      pass_d       = pass_q;
      cc_d         = cc_q;
      epoch_done_d = 1'b0;
      for (int i = 0; i < INPUTS; i++) begin
         values_d[i] = values_q[i];
      end
      for (int k = 0; k < OUTPUTS; k++) begin
         expected_d[k] = expected_q[k];
      end

      last_hold  = (hold_q == LAST_HOLD);
      last_idx   = (idx_q == LAST_IDX);
      epoch_inc  = epoch_q + EW'(1);
      pass_total = pass_q + CW'(sample_hit);
      stop_now   = !(epoch_inc < EPOCHS_V);
`ifdef MLP_SCHED_EARLY_STOP_EN
      stop_now   = stop_now || (pass_total == ALL_HITS);
`endif

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = TRAIN;
               idx_d   = '0;
               hold_d  = '0;
               epoch_d = '0;
               pass_d  = '0;
            end
         end
         TRAIN: begin
            if (abort) begin
               state_d = IDLE;
               hold_d  = '0;
            end else if (last_hold) begin
               hold_d = '0;
               if (last_idx) begin
                  state_d = EVAL;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         EVAL: begin
            if (abort) begin
               state_d = IDLE;
               hold_d  = '0;
            end else if (last_hold) begin
               hold_d = '0;
               if (last_idx) begin
                  // End of epoch: publish the score and decide whether to continue.
                  idx_d        = '0;
                  pass_d       = '0;
                  cc_d         = pass_total;
                  epoch_d      = epoch_inc;
                  epoch_done_d = 1'b1;
                  state_d      = stop_now ? DONE : TRAIN;
               end else begin
                  pass_d = pass_total;
                  idx_d  = idx_q + IW'(1);
               end
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d     = (state_d == TRAIN) || (state_d == EVAL);
      training_d = (state_d == TRAIN);
      done_d     = (state_d == DONE);

      // Registered table read: drive the entry the next cycle will present.
      if (busy_d) begin
         for (int i = 0; i < INPUTS; i++) begin
            values_d[i] = tbl_values_q[idx_d][i];
         end
         for (int k = 0; k < OUTPUTS; k++) begin
            expected_d[k] = tbl_expected_q[idx_d][k];
         end
      end
   end

   // State machine register with registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         hold_q       <= '0;
         epoch_q      <= '0;
         pass_q       <= '0;
         cc_q         <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         training_q   <= 1'b0;
         epoch_done_q <= 1'b0;
         for (int i = 0; i < INPUTS; i++) begin
            values_q[i] <= 0.0;
         end
         for (int k = 0; k < OUTPUTS; k++) begin
            expected_q[k] <= 0.0;
         end
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         hold_q       <= hold_d;
         epoch_q      <= epoch_d;
         pass_q       <= pass_d;
         cc_q         <= cc_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         training_q   <= training_d;
         epoch_done_q <= epoch_done_d;
         for (int i = 0; i < INPUTS; i++) begin
            values_q[i] <= values_d[i];
         end
         for (int k = 0; k < OUTPUTS; k++) begin
            expected_q[k] <= expected_d[k];
         end
      end
   end

endmodule
